instr_issue_unit: RTL and testbench

INSTR_ISSUE_UNIT -- requirements
Module: instr_issue_unit

---
 rtl/instr_issue_unit.sv | 126 ++++++++++++
 tb/tb_instr_issue_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_unit.sv
// In-order instruction issue unit: a small FIFO feeding a hazard-checked,
// bubble-inserting issue stage, with a two-cycle-delayed operand stream.
module instr_issue_unit #(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] BUBBLE_INSTR = 8'hC0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_instr,
  input  logic [7:0]  in_data,
  output logic [7:0]  instr_out,
  output logic [7:0]  data_out,
  output logic        bubble_out,
  output logic [15:0] stall_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [7:0]    mem_i_q [FIFO_DEPTH];
  logic [7:0]    mem_d_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // history index 0 = instruction currently on instr_out (distance 1)
  logic [2:0]      hw_q, hw_d;
  logic [2:0][2:0] hdst_q, hdst_d;

  logic [7:0]  instr_out_q, instr_out_d;
  logic        bubble_out_q, bubble_out_d;
  logic [15:0] stall_q, stall_d;
  logic [7:0]  d1_q, d1_d;
  logic [7:0]  d2_q, d2_d;
  logic [7:0]  data_out_q, data_out_d;

  logic [7:0] head_i;
  logic [7:0] head_d;
  logic       has_head;
  logic       reads;
  logic       hz_rd;
  logic       hz_rt;
  logic       hazard;
  logic       push;
  logic       pop;

  assign in_ready    = !reset && (count_q < CW'(FIFO_DEPTH));
  assign instr_out   = instr_out_q;
  assign bubble_out  = bubble_out_q;
  assign stall_count = stall_q;
  assign data_out    = data_out_q;

  // Hazard detection on the FIFO head and next-state computation
  always_comb begin
    head_i   = mem_i_q[rd_ptr_q];
    head_d   = mem_d_q[rd_ptr_q];
    has_head = (count_q != '0);
    reads    = ~head_i[7];
    hz_rd    = (hw_q[0] && hdst_q[0] == head_i[2:0]) ||
               (hw_q[1] && hdst_q[1] == head_i[2:0]) ||
               (hw_q[2] && hdst_q[2] == head_i[2:0]);
    hz_rt    = (hw_q[0] && hdst_q[0] == head_i[5:3]) ||
               (hw_q[1] && hdst_q[1] == head_i[5:3]);
    hazard   = reads && (hz_rd || hz_rt);
    pop      = has_head && !hazard;
    push     = in_valid && in_ready;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    instr_out_d  = pop ? head_i : BUBBLE_INSTR;
    bubble_out_d = !pop;

    stall_d = stall_q;
    if (has_head && hazard && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;

    hw_d   = {hw_q[1:0], pop && head_i[7:6] != 2'b10};
    hdst_d = {hdst_q[1:0], pop ? head_i[2:0] : 3'b000};

    d1_d       = (pop && head_i[7:6] == 2'b10) ? head_d : 8'h00;
    d2_d       = d1_q;
    data_out_d = d2_q;
  end

  // FIFO storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_i_q[wr_ptr_q] <= in_instr;
      mem_d_q[wr_ptr_q] <= in_data;
    end
  end

  // Control state, history, delay line and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hw_q         <= '0;
      hdst_q       <= '0;
      instr_out_q  <= BUBBLE_INSTR;
      bubble_out_q <= 1'b1;
      stall_q      <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      data_out_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hw_q         <= hw_d;
      hdst_q       <= hdst_d;
      instr_out_q  <= instr_out_d;
      bubble_out_q <= bubble_out_d;
      stall_q      <= stall_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      data_out_q   <= data_out_d;
    end
  end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Bench for instr_issue_unit: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_instr_issue_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_instr = 8'h00;
  logic [7:0]  in_data = 8'h00;
  logic [7:0]  instr_out;
  logic [7:0]  data_out;
  logic        bubble_out;
  logic [15:0] stall_count;

  instr_issue_unit #(.FIFO_DEPTH(DEPTH), .BUBBLE_INSTR(8'hC0)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_data     (in_data),
    .instr_out   (instr_out),
    .data_out    (data_out),
    .bubble_out  (bubble_out),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         vld;
    logic [7:0] i;
    logic [7:0] d;
  } ent_t;

  ent_t mq[$];
  ent_t hist[$];
  int   m_stall;
  bit   acc;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    ent_t b;
    b.vld = 0; b.i = 8'hC0; b.d = 8'h00;
    mq.delete();
    hist.delete();
    repeat (3) hist.push_back(b);
    m_stall = 0;
  endtask

  // One rising edge of the reference model, using pre-edge state
  task automatic model_edge();
    ent_t e, h, nw;
    bit hz;
    acc = in_valid && (mq.size() < DEPTH);
    hz = 0;
    nw.vld = 0; nw.i = 8'hC0; nw.d = 8'h00;
    if (mq.size() > 0) begin
      h = mq[0];
      if (h.i[7] == 1'b0) begin
        for (int k = 1; k <= 3; k++) begin
          e = hist[3-k];
          if (e.vld && e.i[7:6] != 2'b10) begin
            if (e.i[2:0] == h.i[2:0]) hz = 1;
            if (k <= 2 && e.i[2:0] == h.i[5:3]) hz = 1;
          end
        end
      end
      if (hz) begin
        if (m_stall < 65535) m_stall++;
      end else begin
        nw = h;
        nw.vld = 1;
        void'(mq.pop_front());
      end
    end
    if (acc) begin
      e.vld = 1; e.i = in_instr; e.d = in_data;
      mq.push_back(e);
    end
    hist.push_back(nw);
    void'(hist.pop_front());
  endtask

  task automatic check_outputs();
    ent_t cur, old;
    logic [7:0] ed;
    cur = hist[2];
    old = hist[0];
    ed = (old.vld && old.i[7:6] == 2'b10) ? old.d : 8'h00;
    check("instr", instr_out, cur.vld ? cur.i : 8'hC0);
    check("bubble", bubble_out, !cur.vld);
    check("data", data_out, ed);
    check("stall", stall_count, m_stall);
    check("ready", in_ready, mq.size() < DEPTH);
  endtask

  task automatic step(input logic v, input logic [7:0] i,
                      input logic [7:0] d);
    in_valid = v; in_instr = i; in_data = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic push(input logic [7:0] i, input logic [7:0] d);
    int n = 0;
    do begin
      step(1'b1, i, d);
      n++;
    end while (!acc && n < 20);
    if (!acc) check("push_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_instr", instr_out, 8'hC0);
    check("rst_bubble", bubble_out, 1);
    check("rst_data", data_out, 8'h00);
    check("rst_stall", stall_count, 0);
    check("rst_ready", in_ready, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] op;
    logic [2:0] rt, rd;
    model_reset();
    @(negedge clk);
    do_reset();
    idle(2);

    // back-to-back independent instructions
    push(8'h0A, 8'h00);
    push(8'h23, 8'h00);
    idle(4);
    check("r029_stall", stall_count, 0);

    // rd reuse: three bubbles
    do_reset();
    push(8'h0A, 8'h00);
    push(8'h1A, 8'h00);
    idle(6);
    check("r030_stall", stall_count, 3);

    // rt reuse: two bubbles
    do_reset();
    push(8'h0A, 8'h00);
    push(8'h15, 8'h00);
    idle(6);
    check("r031_stall", stall_count, 2);

    // operand delay for opcode 10
    do_reset();
    push(8'h80, 8'h5A);
    idle(5);

    // fill while the head is stalled
    do_reset();
    push(8'h0A, 8'h00);
    push(8'h1A, 8'h00);
    push(8'h23, 8'h00);
    push(8'h2C, 8'h00);
    push(8'h35, 8'h00);
    push(8'h80, 8'h77);
    idle(10);

    // reset in the middle of a stall with pairs buffered
    do_reset();
    push(8'h0A, 8'h00);
    push(8'h1A, 8'h00);
    push(8'h23, 8'h00);
    push(8'h2C, 8'h00);
    do_reset();
    idle(5);

    // random traffic over a small register set to provoke hazards
    for (int c = 0; c < 400; c++) begin
      op = 2'($urandom_range(0, 3));
      rt = 3'($urandom_range(0, 3));
      rd = 3'($urandom_range(0, 3));
      step(1'($urandom_range(0, 3) != 0), {op, rt, rd}, 8'($urandom));
      if (c == 200) do_reset();
    end
    in_valid = 1'b0;
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
